// File: rtl/sha256_round_engine_pkg.sv
// Shared SHA-256 definitions for the round engine and its schedule.
// The package holds the initial hash words, the K constants, the FSM encodings and the
// bitwise round functions of the compression step.
package sha256_round_engine_pkg;

    typedef logic [31:0] word_t;

    // Initial hash value H(0) for a fresh message.
    localparam word_t SHA256_H0 = 32'h6a09e667;
    localparam word_t SHA256_H1 = 32'hbb67ae85;
    localparam word_t SHA256_H2 = 32'h3c6ef372;
    localparam word_t SHA256_H3 = 32'ha54ff53a;
    localparam word_t SHA256_H4 = 32'h510e527f;
    localparam word_t SHA256_H5 = 32'h9b05688c;
    localparam word_t SHA256_H6 = 32'h1f83d9ab;
    localparam word_t SHA256_H7 = 32'h5be0cd19;
    localparam logic [255:0] SHA256_H_INIT = {SHA256_H0, SHA256_H1, SHA256_H2, SHA256_H3,
                                              SHA256_H4, SHA256_H5, SHA256_H6, SHA256_H7};

    // FSM encodings.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_FINAL = 2'd3;

    // Round constants K[0..63].
    localparam word_t K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Upper-case sigma functions act on the working variables.
    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 5'd2) ^ rotr(x, 5'd13) ^ rotr(x, 5'd22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 5'd6) ^ rotr(x, 5'd11) ^ rotr(x, 5'd25);
    endfunction

    // Lower-case sigma functions act on the message schedule.
    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/SHA256_K.sv
// SHA-256 round-constant ROM with a one-cycle registered read: Kt = K[round] one clk later.
module SHA256_K
    import sha256_round_engine_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  round,
    output logic [31:0] Kt
);

    // Registered constant lookup.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Kt <= 32'h0000_0000;
        end else begin
            Kt <= K_TABLE[round];
        end
    end

endmodule

// File: rtl/sha256_w_schedule.sv
// SHA-256 message schedule as a 16-word sliding window.
// The window always holds W[r..r+15], so the word consumed by round r is simply w[0];
// each shift appends the expanded word W[r+16], computed from the current window.
module sha256_w_schedule
    import sha256_round_engine_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] message,
    output logic [31:0]  wr
);

    word_t w_r [16];
    word_t next_w_s;

    // Expanded word W[r+16] from the window W[r..r+15].
    always_comb begin
        next_w_s = small_sigma1(w_r[14]) + w_r[9] + small_sigma0(w_r[1]) + w_r[0];
    end

    // Window register: parallel load of the block, or slide by one word per round.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                w_r[i] <= 32'h0000_0000;
            end
        end else if (load) begin
            for (int i = 0; i < 16; i++) begin
                w_r[i] <= message[511 - 32*i -: 32];
            end
        end else if (shift) begin
            for (int i = 0; i < 15; i++) begin
                w_r[i] <= w_r[i + 1];
            end
            w_r[15] <= next_w_s;
        end else begin
            for (int i = 0; i < 16; i++) begin
                w_r[i] <= w_r[i];
            end
        end
    end

    assign wr = w_r[0];

endmodule

// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression core: one round per clock, chained hash output.
// The K ROM sits outside this block; round is driven one cycle ahead so that the ROM's
// registered Kt lines up with the round being applied.
module sha256_round_engine
    import sha256_round_engine_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [511:0] message,
    input  logic [255:0] h_in,
    output logic [5:0]   round,
    input  logic [31:0]  Kt,
    output logic         busy,
    output logic         done,
    output logic [255:0] h_out
);

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    logic [1:0]   state_r;
    logic [5:0]   r_r;
    logic         busy_r;
    logic         done_r;
    logic [255:0] h_out_r;
    word_t        work_r  [8];   // a..h at index 0..7
    word_t        hsave_r [8];   // chaining value added back in FINAL

    logic         accept_s;
    logic [5:0]   round_s;
    word_t        wr_s;
    word_t        t1_s;
    word_t        t2_s;
    logic [255:0] final_s;

    assign accept_s = (state_r == ST_IDLE) && start;

    sha256_w_schedule u_w_schedule (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept_s),
        .shift   (state_r == ST_ROUND),
        .message (message),
        .wr      (wr_s)
    );

    // ROM address: one round ahead while iterating, otherwise parked on K[0].
    always_comb begin
        case (state_r)
            ST_ROUND: round_s = r_r + 6'd1;
            default:  round_s = 6'd0;
        endcase
    end

    // Round temporaries for the round currently being applied.
    always_comb begin
        t1_s = work_r[7] + big_sigma1(work_r[4]) + ch(work_r[4], work_r[5], work_r[6]) + Kt + wr_s;
        t2_s = big_sigma0(work_r[0]) + maj(work_r[0], work_r[1], work_r[2]);
    end

    // Chained result: saved hash plus final working variables, word by word.
    always_comb begin
        final_s = '0;
        for (int i = 0; i < 8; i++) begin
            final_s[255 - 32*i -: 32] = hsave_r[i] + work_r[i];
        end
    end

    // Control FSM, working variables and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            r_r     <= 6'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            h_out_r <= 256'h0;
            for (int i = 0; i < 8; i++) begin
                work_r[i]  <= 32'h0000_0000;
                hsave_r[i] <= 32'h0000_0000;
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_PRIME;
                        busy_r  <= 1'b1;
                        for (int i = 0; i < 8; i++) begin
                            work_r[i]  <= h_in[255 - 32*i -: 32];
                            hsave_r[i] <= h_in[255 - 32*i -: 32];
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PRIME: begin
                    state_r <= ST_ROUND;
                    r_r     <= 6'd0;
                end
                ST_ROUND: begin
                    work_r[0] <= t1_s + t2_s;
                    work_r[1] <= work_r[0];
                    work_r[2] <= work_r[1];
                    work_r[3] <= work_r[2];
                    work_r[4] <= work_r[3] + t1_s;
                    work_r[5] <= work_r[4];
                    work_r[6] <= work_r[5];
                    work_r[7] <= work_r[6];
                    r_r       <= r_r + 6'd1;
                    if (r_r == LAST_ROUND) begin
                        state_r <= ST_FINAL;
                    end else begin
                        state_r <= ST_ROUND;
                    end
                end
                ST_FINAL: begin
                    h_out_r <= final_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign round = round_s;
    assign busy  = busy_r;
    assign done  = done_r;
    assign h_out = h_out_r;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine with the K ROM instantiated beside it.
module tb_sha256_round_engine;
    import sha256_round_engine_pkg::*;

    localparam logic [511:0] ABC_MSG   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [511:0] EMPTY_MSG = {32'h80000000, 480'h0};
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [511:0] TWO_B1    = {448'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071,
                                          32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2    = {480'h0, 32'h000001c0};
    localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [511:0] message;
    logic [255:0] h_in;
    logic [5:0]   round;
    logic [31:0]  kt;
    logic         busy;
    logic         done;
    logic [255:0] h_out;

    int checks   = 0;
    int failures = 0;

    logic [255:0] dig;
    logic [255:0] dig1;
    int           dc;
    int           bc;

    always #5 clk = ~clk;

    sha256_round_engine #(.ROUNDS(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .message (message),
        .h_in    (h_in),
        .round   (round),
        .Kt      (kt),
        .busy    (busy),
        .done    (done),
        .h_out   (h_out)
    );

    SHA256_K u_k (
        .clk     (clk),
        .reset_n (reset_n),
        .round   (round),
        .Kt      (kt)
    );

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected ROM address in cycle c after the start edge (c=0 is PRIME, 65 is FINAL).
    function automatic logic [5:0] exp_round(input int c);
        if (c >= 1 && c <= 63) return 6'(c);
        else return 6'd0;
    endfunction

    // Called at a negedge: requests a block, then watches until done (bounded).
    task automatic run_block(input logic [511:0] msg, input logic [255:0] hin, input bit trace,
                             input bit poke, output logic [255:0] d, output int done_cyc,
                             output int busy_cnt);
        message  = msg;
        h_in     = hin;
        start    = 1'b1;
        done_cyc = -1;
        busy_cnt = 0;
        d        = '0;
        for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                start   = 1'b0;
                message = '0;
                h_in    = '0;
            end
            if (poke && (cyc == 11 || cyc == 65)) start = 1'b1;
            if (poke && cyc == 12) start = 1'b0;
            if (busy) busy_cnt++;
            if (trace && cyc <= 65) check_eq($sformatf("round_c%0d", cyc), {250'h0, round}, {250'h0, exp_round(cyc)});
            if (done) begin
                done_cyc = cyc;
                d        = h_out;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        message = '0;
        h_in    = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",  {255'h0, busy}, 256'h0);
        check_eq("rst_done",  {255'h0, done}, 256'h0);
        check_eq("rst_h_out", h_out, 256'h0);
        check_eq("rst_round", {250'h0, round}, 256'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // "abc" with full address trace and timing.
        run_block(ABC_MSG, SHA256_H_INIT, 1'b1, 1'b0, dig, dc, bc);
        check_eq("abc_digest", dig, ABC_DIG);
        check_eq("abc_done_edge", dc, 256'd66);
        check_eq("abc_busy_cycles", bc, 256'd66);
        @(negedge clk);
        check_eq("abc_done_width", {255'h0, done}, 256'h0);
        check_eq("abc_h_out_held", h_out, ABC_DIG);

        // Empty message.
        run_block(EMPTY_MSG, SHA256_H_INIT, 1'b0, 1'b0, dig, dc, bc);
        check_eq("empty_digest", dig, EMPTY_DIG);
        check_eq("empty_done_edge", dc, 256'd66);

        // Two blocks back to back: block 2 requested in block 1's done cycle.
        @(negedge clk);
        run_block(TWO_B1, SHA256_H_INIT, 1'b0, 1'b0, dig1, dc, bc);
        check_eq("two_b1_done_edge", dc, 256'd66);
        run_block(TWO_B2, dig1, 1'b0, 1'b0, dig, dc, bc);
        check_eq("two_digest", dig, TWO_DIG);
        check_eq("two_b2_done_edge", dc, 256'd66);
        check_eq("two_b2_busy_cycles", bc, 256'd66);

        // start pulses during ROUND r=10 and during FINAL must be ignored.
        @(negedge clk);
        run_block(ABC_MSG, SHA256_H_INIT, 1'b0, 1'b1, dig, dc, bc);
        check_eq("poke_digest", dig, ABC_DIG);
        check_eq("poke_done_edge", dc, 256'd66);
        check_eq("poke_busy_cycles", bc, 256'd66);
        @(negedge clk);
        check_eq("poke_final_start_ignored", {255'h0, busy}, 256'h0);

        // Reset in the middle of round 30, then a clean restart.
        @(negedge clk);
        message = ABC_MSG;
        h_in    = SHA256_H_INIT;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        check_eq("mid_round_addr", {250'h0, round}, 256'd31);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_busy",  {255'h0, busy}, 256'h0);
        check_eq("mid_rst_done",  {255'h0, done}, 256'h0);
        check_eq("mid_rst_h_out", h_out, 256'h0);
        check_eq("mid_rst_round", {250'h0, round}, 256'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_block(ABC_MSG, SHA256_H_INIT, 1'b0, 1'b0, dig, dc, bc);
        check_eq("restart_digest", dig, ABC_DIG);
        check_eq("restart_done_edge", dc, 256'd66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
